// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/ripple_slice.sv
// Combinational DIGIT-bit adder slice used once per serial step.
module ripple_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] total;

  assign total = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign s     = total[DIGIT-1:0];
  assign co    = total[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial unsigned adder: adds DIGIT bits per cycle, LSB slice first,
// and pulses done for one cycle when {cout,sum} holds a+b+cin.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       a_reg, b_reg, sum_reg;
  logic                   carry_reg, cout_reg;
  logic [CNT_W-1:0]       step_cnt;
  logic                   accept, last_step;
  logic [DIGIT-1:0]       slice_s;
  logic                   slice_co;
  logic [WIDTH+DIGIT-1:0] sum_cat;

  ripple_slice #(.DIGIT(DIGIT)) u_slice (
    .x  (a_reg[DIGIT-1:0]),
    .y  (b_reg[DIGIT-1:0]),
    .cin(carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  assign last_step = (step_cnt == LAST);
  // New slice enters at the MSB end; after STEPS shifts the result is aligned.
  assign sum_cat   = {slice_s, sum_reg};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      step_cnt  <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
      step_cnt  <= '0;
    end else if (state == RUN) begin
      a_reg     <= a_reg >> DIGIT;
      b_reg     <= b_reg >> DIGIT;
      carry_reg <= slice_co;
      sum_reg   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
      step_cnt  <= step_cnt + CNT_W'(1);
      if (last_step) cout_reg <= slice_co;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
